// File: rtl/fpga_version_regs.sv
// fpga_version_regs: AXI4-Lite slave reporting the running image version
// (regular or golden), a synchronised image status bit, a byte-strobed
// scratch register, build-ID words and a seconds uptime counter with
// software clear. Decode uses address bits [7:2]; the map aliases every
// 256 bytes.
//
// Ports:
//   SysClk_ClkIn / SysRst_RstIn    clock, async active-high reset
//   GoldenImageN_EnaIn             low = golden image running (async)
//   AxiWriteAddr*/AxiWriteData*    AW and W channels (prot ignored)
//   AxiWriteResp*                  B channel
//   AxiReadAddr*                   AR channel (prot ignored)
//   AxiReadData*                   R channel
module fpga_version_regs #(
    parameter logic [15:0]  VersionNumber_Gen        = 16'h0000,
    parameter logic [15:0]  VersionNumber_Golden_Gen = 16'h0000,
    parameter int unsigned  NumIdWords_Gen           = 4,
    parameter logic [255:0] IdWords_Gen              = 256'h0,
    parameter int unsigned  ClkFreqHz_Gen            = 50000000
) (
    input  logic        SysClk_ClkIn,
    input  logic        SysRst_RstIn,
    input  logic        GoldenImageN_EnaIn,
    input  logic        AxiWriteAddrValid_ValIn,
    output logic        AxiWriteAddrReady_RdyOut,
    input  logic [15:0] AxiWriteAddrAddress_AdrIn,
    input  logic [2:0]  AxiWriteAddrProt_DatIn,
    input  logic        AxiWriteDataValid_ValIn,
    output logic        AxiWriteDataReady_RdyOut,
    input  logic [31:0] AxiWriteDataData_DatIn,
    input  logic [3:0]  AxiWriteDataStrobe_DatIn,
    output logic        AxiWriteRespValid_ValOut,
    input  logic        AxiWriteRespReady_RdyIn,
    output logic [1:0]  AxiWriteRespResponse_DatOut,
    input  logic        AxiReadAddrValid_ValIn,
    output logic        AxiReadAddrReady_RdyOut,
    input  logic [15:0] AxiReadAddrAddress_AdrIn,
    input  logic [2:0]  AxiReadAddrProt_DatIn,
    output logic        AxiReadDataValid_ValOut,
    input  logic        AxiReadDataReady_RdyIn,
    output logic [1:0]  AxiReadDataResponse_DatOut,
    output logic [31:0] AxiReadDataData_DatOut
);
    localparam int unsigned PreW = (ClkFreqHz_Gen > 1) ? $clog2(ClkFreqHz_Gen) : 1;
    localparam logic [PreW-1:0] PreTerm = PreW'(ClkFreqHz_Gen - 1);
    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespSlvErr = 2'b10;
    localparam logic [5:0] AdrVersion = 6'h00;
    localparam logic [5:0] AdrStatus  = 6'h01;
    localparam logic [5:0] AdrScratch = 6'h02;
    localparam logic [5:0] AdrIdCount = 6'h03;
    localparam logic [5:0] AdrUptime  = 6'h04;
    localparam logic [5:0] AdrControl = 6'h05;

    typedef enum logic {W_IDLE, W_RESP} wr_state_t;
    typedef enum logic {R_IDLE, R_DATA} rd_state_t;

    // ID slot i lives at word address 8+i and exists only below the count
    function automatic logic id_slot_ok(input logic [5:0] adr);
        return (adr[5:3] == 3'b001) && (32'(adr[2:0]) < NumIdWords_Gen);
    endfunction

    function automatic logic wr_map_ok(input logic [5:0] adr);
        return (adr <= AdrControl) || id_slot_ok(adr);
    endfunction

    // Address bits outside [7:2] and the prot fields carry no meaning here
    logic w_unused;
    assign w_unused = ^{AxiWriteAddrProt_DatIn, AxiReadAddrProt_DatIn,
                        AxiWriteAddrAddress_AdrIn[15:8], AxiWriteAddrAddress_AdrIn[1:0],
                        AxiReadAddrAddress_AdrIn[15:8], AxiReadAddrAddress_AdrIn[1:0]};

    // Golden-image select synchroniser; idles at "regular image"
    logic r_golden_meta, r_golden_sync;
    always_ff @(posedge SysClk_ClkIn or posedge SysRst_RstIn) begin
        if (SysRst_RstIn) begin
            r_golden_meta <= 1'b1;
            r_golden_sync <= 1'b1;
        end else begin
            r_golden_meta <= GoldenImageN_EnaIn;
            r_golden_sync <= r_golden_meta;
        end
    end

    // ---------------- write channel FSM ----------------
    wr_state_t   r_wstate, w_wstate_nxt;
    logic        r_aw_got, w_aw_got_nxt, r_w_got, w_w_got_nxt;
    logic [5:0]  r_awadr, w_awadr_nxt;
    logic [31:0] r_wdata, w_wdata_nxt;
    logic [3:0]  r_wstrb, w_wstrb_nxt;
    logic        r_awready, w_awready_nxt, r_wready, w_wready_nxt;
    logic        r_bvalid, w_bvalid_nxt;
    logic [1:0]  r_bresp, w_bresp_nxt;
    logic        w_wr_en, w_aw_hs, w_w_hs;

    assign w_aw_hs = AxiWriteAddrValid_ValIn & r_awready;
    assign w_w_hs  = AxiWriteDataValid_ValIn & r_wready;

    always_ff @(posedge SysClk_ClkIn or posedge SysRst_RstIn) begin
        if (SysRst_RstIn) begin
            r_wstate  <= W_IDLE;
            r_aw_got  <= 1'b0;
            r_w_got   <= 1'b0;
            r_awadr   <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bresp   <= RespOkay;
        end else begin
            r_wstate  <= w_wstate_nxt;
            r_aw_got  <= w_aw_got_nxt;
            r_w_got   <= w_w_got_nxt;
            r_awadr   <= w_awadr_nxt;
            r_wdata   <= w_wdata_nxt;
            r_wstrb   <= w_wstrb_nxt;
            r_awready <= w_awready_nxt;
            r_wready  <= w_wready_nxt;
            r_bvalid  <= w_bvalid_nxt;
            r_bresp   <= w_bresp_nxt;
        end
    end

    // AW and W latch independently; the register update fires on the edge
    // where the second of the two is accepted.
    always_comb begin
        w_wstate_nxt  = r_wstate;
        w_aw_got_nxt  = r_aw_got;
        w_w_got_nxt   = r_w_got;
        w_awadr_nxt   = r_awadr;
        w_wdata_nxt   = r_wdata;
        w_wstrb_nxt   = r_wstrb;
        w_awready_nxt = 1'b0;
        w_wready_nxt  = 1'b0;
        w_bvalid_nxt  = r_bvalid;
        w_bresp_nxt   = r_bresp;
        w_wr_en       = 1'b0;
        case (r_wstate)
            W_IDLE: begin
                if (w_aw_hs) begin
                    w_aw_got_nxt = 1'b1;
                    w_awadr_nxt  = AxiWriteAddrAddress_AdrIn[7:2];
                end
                if (w_w_hs) begin
                    w_w_got_nxt = 1'b1;
                    w_wdata_nxt = AxiWriteDataData_DatIn;
                    w_wstrb_nxt = AxiWriteDataStrobe_DatIn;
                end
                if (w_aw_got_nxt && w_w_got_nxt) begin
                    w_wr_en      = 1'b1;
                    w_wstate_nxt = W_RESP;
                    w_bvalid_nxt = 1'b1;
                    w_bresp_nxt  = wr_map_ok(w_awadr_nxt) ? RespOkay : RespSlvErr;
                    w_aw_got_nxt = 1'b0;
                    w_w_got_nxt  = 1'b0;
                end else begin
                    w_awready_nxt = ~w_aw_got_nxt;
                    w_wready_nxt  = ~w_w_got_nxt;
                end
            end
            W_RESP: begin
                if (AxiWriteRespReady_RdyIn) begin
                    w_wstate_nxt = W_IDLE;
                    w_bvalid_nxt = 1'b0;
                    w_bresp_nxt  = RespOkay;
                end
            end
            default: w_wstate_nxt = W_IDLE;
        endcase
    end

    // ---------------- register file ----------------
    logic [31:0]     r_scratch, r_uptime;
    logic [PreW-1:0] r_presc;
    logic            w_clear, w_tick;

    always_ff @(posedge SysClk_ClkIn or posedge SysRst_RstIn) begin
        if (SysRst_RstIn) begin
            r_scratch <= '0;
        end else if (w_wr_en && (w_awadr_nxt == AdrScratch)) begin
            for (int b = 0; b < 4; b++) begin
                if (w_wstrb_nxt[b]) r_scratch[8*b +: 8] <= w_wdata_nxt[8*b +: 8];
            end
        end
    end

    // Seconds counter; a software clear overrides a coincident tick
    assign w_clear = w_wr_en && (w_awadr_nxt == AdrControl) && w_wdata_nxt[0];
    assign w_tick  = (r_presc == PreTerm);

    always_ff @(posedge SysClk_ClkIn or posedge SysRst_RstIn) begin
        if (SysRst_RstIn) begin
            r_presc  <= '0;
            r_uptime <= '0;
        end else if (w_clear) begin
            r_presc  <= '0;
            r_uptime <= '0;
        end else if (w_tick) begin
            r_presc  <= '0;
            r_uptime <= r_uptime + 32'd1;
        end else begin
            r_presc  <= r_presc + PreW'(1);
        end
    end

    // ---------------- read channel FSM ----------------
    rd_state_t   r_rstate, w_rstate_nxt;
    logic        r_arready, w_arready_nxt, r_rvalid, w_rvalid_nxt;
    logic [31:0] r_rdata, w_rdata_nxt, w_rd_data;
    logic [1:0]  r_rresp, w_rresp_nxt, w_rd_resp;
    logic [5:0]  w_ar_adr;
    logic        w_ar_hs;

    assign w_ar_adr = AxiReadAddrAddress_AdrIn[7:2];
    assign w_ar_hs  = AxiReadAddrValid_ValIn & r_arready;

    // Read mux
    always_comb begin
        w_rd_data = '0;
        w_rd_resp = RespOkay;
        case (w_ar_adr)
            AdrVersion: w_rd_data = r_golden_sync ? {VersionNumber_Gen, 16'h0000}
                                                  : {16'h0000, VersionNumber_Golden_Gen};
            AdrStatus:  w_rd_data = {31'h0, ~r_golden_sync};
            AdrScratch: w_rd_data = r_scratch;
            AdrIdCount: w_rd_data = 32'(NumIdWords_Gen);
            AdrUptime:  w_rd_data = r_uptime;
            AdrControl: w_rd_data = '0;
            default: begin
                if (id_slot_ok(w_ar_adr)) w_rd_data = IdWords_Gen[{w_ar_adr[2:0], 5'b00000} +: 32];
                else                      w_rd_resp = RespSlvErr;
            end
        endcase
    end

    always_ff @(posedge SysClk_ClkIn or posedge SysRst_RstIn) begin
        if (SysRst_RstIn) begin
            r_rstate  <= R_IDLE;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
            r_rresp   <= RespOkay;
        end else begin
            r_rstate  <= w_rstate_nxt;
            r_arready <= w_arready_nxt;
            r_rvalid  <= w_rvalid_nxt;
            r_rdata   <= w_rdata_nxt;
            r_rresp   <= w_rresp_nxt;
        end
    end

    always_comb begin
        w_rstate_nxt  = r_rstate;
        w_arready_nxt = 1'b0;
        w_rvalid_nxt  = r_rvalid;
        w_rdata_nxt   = r_rdata;
        w_rresp_nxt   = r_rresp;
        case (r_rstate)
            R_IDLE: begin
                if (w_ar_hs) begin
                    w_rstate_nxt = R_DATA;
                    w_rvalid_nxt = 1'b1;
                    w_rdata_nxt  = w_rd_data;
                    w_rresp_nxt  = w_rd_resp;
                end else begin
                    w_arready_nxt = 1'b1;
                end
            end
            R_DATA: begin
                if (AxiReadDataReady_RdyIn) begin
                    w_rstate_nxt  = R_IDLE;
                    w_rvalid_nxt  = 1'b0;
                    w_arready_nxt = 1'b1;
                end
            end
            default: w_rstate_nxt = R_IDLE;
        endcase
    end

    assign AxiWriteAddrReady_RdyOut    = r_awready;
    assign AxiWriteDataReady_RdyOut    = r_wready;
    assign AxiWriteRespValid_ValOut    = r_bvalid;
    assign AxiWriteRespResponse_DatOut = r_bresp;
    assign AxiReadAddrReady_RdyOut     = r_arready;
    assign AxiReadDataValid_ValOut     = r_rvalid;
    assign AxiReadDataResponse_DatOut  = r_rresp;
    assign AxiReadDataData_DatOut      = r_rdata;

endmodule

// File: tb/tb_fpga_version_regs.sv
// Self-checking bench for fpga_version_regs: randomized AXI-Lite traffic
// compared against a register-map reference model.
module tb_fpga_version_regs;
    localparam logic [15:0]  VER     = 16'h0102;
    localparam logic [15:0]  GVER    = 16'h0007;
    localparam int unsigned  NUM_ID  = 2;
    localparam logic [255:0] ID_WORDS = {128'h0, 32'h0BAD_0003, 32'hCAFE_F00D,
                                         32'h1234_5678, 32'hDEAD_BEEF};
    localparam int unsigned  FREQ    = 10;

    logic        clk = 1'b0, rst = 1'b1, golden_n = 1'b1;
    logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b1, arvalid = 1'b0, rready = 1'b1;
    logic [15:0] awaddr = '0, araddr = '0;
    logic [2:0]  awprot = '0, arprot = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        awready, wready, bvalid, arready, rvalid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;

    int checks = 0, failures = 0;
    logic [31:0] m_scratch = '0;   // model of scratch contents
    int unsigned ep = 0;           // clock edges since reset release or last clear
    logic        tb_clr = 1'b0;    // a clear commits at the coming edge

    fpga_version_regs #(
        .VersionNumber_Gen(VER), .VersionNumber_Golden_Gen(GVER),
        .NumIdWords_Gen(NUM_ID), .IdWords_Gen(ID_WORDS), .ClkFreqHz_Gen(FREQ)
    ) dut (
        .SysClk_ClkIn(clk), .SysRst_RstIn(rst), .GoldenImageN_EnaIn(golden_n),
        .AxiWriteAddrValid_ValIn(awvalid), .AxiWriteAddrReady_RdyOut(awready),
        .AxiWriteAddrAddress_AdrIn(awaddr), .AxiWriteAddrProt_DatIn(awprot),
        .AxiWriteDataValid_ValIn(wvalid), .AxiWriteDataReady_RdyOut(wready),
        .AxiWriteDataData_DatIn(wdata), .AxiWriteDataStrobe_DatIn(wstrb),
        .AxiWriteRespValid_ValOut(bvalid), .AxiWriteRespReady_RdyIn(bready),
        .AxiWriteRespResponse_DatOut(bresp),
        .AxiReadAddrValid_ValIn(arvalid), .AxiReadAddrReady_RdyOut(arready),
        .AxiReadAddrAddress_AdrIn(araddr), .AxiReadAddrProt_DatIn(arprot),
        .AxiReadDataValid_ValOut(rvalid), .AxiReadDataReady_RdyIn(rready),
        .AxiReadDataResponse_DatOut(rresp), .AxiReadDataData_DatOut(rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst)         ep <= 0;
        else if (tb_clr) ep <= 0;
        else             ep <= ep + 1;
    end

    // Reference register map: returns {resp, data}
    function automatic logic [33:0] model_read(input logic [15:0] addr, input logic gn,
                                               input logic [31:0] scr, input logic [31:0] up);
        int off;
        logic [255:0] ids;
        ids = ID_WORDS;
        off = int'(addr[7:0]) & 'hFC;
        if (off == 'h00) return {2'b00, gn ? {VER, 16'h0} : {16'h0, GVER}};
        if (off == 'h04) return {2'b00, 31'h0, !gn};
        if (off == 'h08) return {2'b00, scr};
        if (off == 'h0C) return {2'b00, 32'(NUM_ID)};
        if (off == 'h10) return {2'b00, up};
        if (off == 'h14) return {2'b00, 32'h0};
        if (off >= 'h20 && off < 'h20 + 4 * int'(NUM_ID)) return {2'b00, ids[(off - 'h20) * 8 +: 32]};
        return {2'b10, 32'h0};
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    // lead > 0: W beat that many cycles before AW; lead < 0: AW first
    task automatic do_write(input logic [15:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int lead, output logic [1:0] resp, output int lat);
        int gap, n;
        n = 0;
        while (!(awready && wready) && n < 50) begin @(negedge clk); n++; end
        gap = (lead < 0) ? -lead : lead;
        awaddr = addr; wdata = data; wstrb = strb;
        if (gap != 0) begin
            if (lead > 0) wvalid = 1'b1; else awvalid = 1'b1;
            @(negedge clk);
            wvalid = 1'b0; awvalid = 1'b0;
            repeat (gap - 1) @(negedge clk);
            if (lead > 0) awvalid = 1'b1; else wvalid = 1'b1;
        end else begin
            awvalid = 1'b1; wvalid = 1'b1;
        end
        tb_clr = ((addr & 16'h00FC) == 16'h0014) && data[0];
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0; tb_clr = 1'b0;
        lat = 1;
        while (!bvalid && lat < 20) begin @(negedge clk); lat++; end
        resp = bresp;
    endtask

    task automatic do_read(input logic [15:0] addr, output logic [31:0] data, output logic [1:0] resp,
                           output logic [31:0] up, output int lat);
        int n;
        n = 0;
        while (!arready && n < 50) begin @(negedge clk); n++; end
        araddr = addr; arvalid = 1'b1; up = ep / FREQ;
        @(negedge clk);
        arvalid = 1'b0;
        lat = 1;
        while (!rvalid && lat < 20) begin @(negedge clk); lat++; end
        data = rdata; resp = rresp;
    endtask

    task automatic test_reset();
        logic [31:0] d, up; logic [1:0] r; int lat;
        rst = 1'b1; golden_n = 1'b1; m_scratch = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({awready, wready, arready, bvalid, rvalid, bresp, rresp, rdata} !== '0) begin
            failures++; $display("FAIL reset_outputs got=%b exp=0", {awready, wready, arready, bvalid, rvalid});
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({awready, wready, arready} !== 3'b111) begin
            failures++; $display("FAIL ready_after_reset got=%b exp=111", {awready, wready, arready});
        end
        do_read(16'h0000, d, r, up, lat);
        checks++;
        if ({r, d} !== {2'b00, 32'h0102_0000}) begin
            failures++; $display("FAIL version_regular got=%h exp=%h", {r, d}, {2'b00, 32'h0102_0000});
        end
        checks++;
        if (lat != 1) begin failures++; $display("FAIL read_latency got=%0d exp=1", lat); end
    endtask

    task automatic test_golden();
        logic [31:0] d, up; logic [1:0] r; int lat;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            golden_n = (i == 0) ? 1'b0 : 1'($urandom_range(1));
            repeat (3) @(negedge clk);
            do_read(16'h0000, d, r, up, lat);
            checks++;
            if ({r, d} !== model_read(16'h0000, golden_n, m_scratch, up)) begin
                failures++; $display("FAIL golden_version got=%h exp=%h", {r, d}, model_read(16'h0000, golden_n, m_scratch, up));
            end
            do_read(16'h0004, d, r, up, lat);
            checks++;
            if ({r, d} !== model_read(16'h0004, golden_n, m_scratch, up)) begin
                failures++; $display("FAIL golden_status got=%h exp=%h", {r, d}, model_read(16'h0004, golden_n, m_scratch, up));
            end
        end
        golden_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_scratch();
        logic [31:0] d, up, wd; logic [1:0] r; logic [3:0] s; logic [15:0] a; int lat, lead;
        do_write(16'h0008, 32'hAABB_CCDD, 4'b0101, 3, r, lat);
        m_scratch = merge(m_scratch, 32'hAABB_CCDD, 4'b0101);
        checks++;
        if (r !== 2'b00 || lat != 1) begin failures++; $display("FAIL scratch_wr_resp got=%b/%0d exp=00/1", r, lat); end
        do_read(16'h0008, d, r, up, lat);
        checks++;
        if ({r, d} !== {2'b00, 32'h00BB_00DD}) begin failures++; $display("FAIL scratch_strobe got=%h exp=%h", {r, d}, {2'b00, 32'h00BB_00DD}); end
        for (int i = 0; i < 10; i++) begin
            wd = $urandom; s = 4'($urandom); lead = int'($urandom_range(6)) - 3;
            a = {8'($urandom), 6'h02, 2'($urandom)};
            do_write(a, wd, s, lead, r, lat);
            m_scratch = merge(m_scratch, wd, s);
            checks++;
            if (r !== 2'b00 || lat != 1) begin failures++; $display("FAIL scratch_rand_wr got=%b/%0d exp=00/1", r, lat); end
            a = {8'($urandom), 6'h02, 2'($urandom)};
            do_read(a, d, r, up, lat);
            checks++;
            if ({r, d} !== {2'b00, m_scratch}) begin failures++; $display("FAIL scratch_rand_rd got=%h exp=%h", {r, d}, {2'b00, m_scratch}); end
        end
    endtask

    task automatic test_id_errors();
        logic [31:0] d, up; logic [1:0] r; logic [15:0] a; int lat;
        logic [15:0] fixed [6];
        fixed = '{16'h0020, 16'h0024, 16'h0028, 16'h003C, 16'h000C, 16'h0018};
        for (int i = 0; i < 6; i++) begin
            do_read(fixed[i], d, r, up, lat);
            checks++;
            if ({r, d} !== model_read(fixed[i], golden_n, m_scratch, up)) begin
                failures++; $display("FAIL id_map_%h got=%h exp=%h", fixed[i], {r, d}, model_read(fixed[i], golden_n, m_scratch, up));
            end
        end
        do_write(16'h0040, $urandom, 4'hF, 0, r, lat);
        checks++;
        if (r !== 2'b10) begin failures++; $display("FAIL unmapped_wr_resp got=%b exp=10", r); end
        do_write(16'h0000, $urandom, 4'hF, -1, r, lat);
        checks++;
        if (r !== 2'b00) begin failures++; $display("FAIL ro_wr_resp got=%b exp=00", r); end
        do_read(16'h0008, d, r, up, lat);
        checks++;
        if ({r, d} !== {2'b00, m_scratch}) begin failures++; $display("FAIL unmapped_wr_effect got=%h exp=%h", {r, d}, {2'b00, m_scratch}); end
        do_read(16'h0000, d, r, up, lat);
        checks++;
        if ({r, d} !== {2'b00, 32'h0102_0000}) begin failures++; $display("FAIL ro_wr_effect got=%h exp=%h", {r, d}, {2'b00, 32'h0102_0000}); end
        for (int i = 0; i < 12; i++) begin
            a = 16'($urandom);
            do_read(a, d, r, up, lat);
            checks++;
            if ({r, d} !== model_read(a, golden_n, m_scratch, up)) begin
                failures++; $display("FAIL rand_read_%h got=%h exp=%h", a, {r, d}, model_read(a, golden_n, m_scratch, up));
            end
        end
    endtask

    task automatic test_uptime();
        logic [31:0] d, up; logic [1:0] r; int lat, n;
        rst = 1'b1; m_scratch = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        while (ep < 35) @(negedge clk);
        do_read(16'h0010, d, r, up, lat);
        checks++;
        if ({r, d} !== {2'b00, 32'd3} || up != 32'd3) begin failures++; $display("FAIL uptime_35 got=%h exp=%h", {r, d}, {2'b00, 32'd3}); end
        // clear lands on the prescaler terminal count
        n = 0;
        while (!((ep % FREQ) == FREQ - 1 && awready && wready) && n < 100) begin @(negedge clk); n++; end
        do_write(16'h0014, 32'h1, 4'hF, 0, r, lat);
        checks++;
        if (r !== 2'b00) begin failures++; $display("FAIL clear_resp got=%b exp=00", r); end
        do_read(16'h0010, d, r, up, lat);
        checks++;
        if ({r, d} !== {2'b00, 32'd0}) begin failures++; $display("FAIL uptime_cleared got=%h exp=0", {r, d}); end
        while (ep < FREQ - 1) @(negedge clk);
        do_read(16'h0010, d, r, up, lat);
        checks++;
        if (d !== 32'd0) begin failures++; $display("FAIL uptime_before_tick got=%h exp=0", d); end
        do_write(16'h0114, 32'h1, 4'hF, 0, r, lat);
        while (ep < FREQ) @(negedge clk);
        do_read(16'h0010, d, r, up, lat);
        checks++;
        if (d !== 32'd1 || up != 32'd1) begin failures++; $display("FAIL uptime_first_tick got=%h exp=1", d); end
    endtask

    task automatic test_concurrent();
        logic [31:0] d, d2, up, wd; logic [1:0] r, r2; int lat, lat2, n;
        logic [31:0] old;
        old = m_scratch; wd = $urandom;
        n = 0;
        while (!(awready && wready && arready) && n < 50) begin @(negedge clk); n++; end
        fork
            do_write(16'h0008, wd, 4'hF, 0, r2, lat2);
            do_read(16'h0008, d, r, up, lat);
        join
        m_scratch = wd;
        checks++;
        if ({r, d} !== {2'b00, old}) begin failures++; $display("FAIL same_cycle_rd got=%h exp=%h", {r, d}, {2'b00, old}); end
        do_read(16'h0008, d2, r, up, lat);
        checks++;
        if (d2 !== wd) begin failures++; $display("FAIL after_concurrent got=%h exp=%h", d2, wd); end
    endtask

    task automatic test_back_to_back();
        int n;
        n = 0;
        while (!arready && n < 50) begin @(negedge clk); n++; end
        araddr = 16'h000C; arvalid = 1'b1; rready = 1'b0;
        @(negedge clk);
        arvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({rvalid, arready, rresp, rdata} !== {1'b1, 1'b0, 2'b00, 32'd2}) begin
                failures++; $display("FAIL rready_hold_%0d got=%h exp=%h", i, {rvalid, arready, rresp, rdata}, {1'b1, 1'b0, 2'b00, 32'd2});
            end
            @(negedge clk);
        end
        rready = 1'b1;
        @(negedge clk);
        checks++;
        if ({rvalid, arready} !== 2'b01) begin failures++; $display("FAIL rready_release got=%b exp=01", {rvalid, arready}); end
        n = 0;
        while (!(awready && wready) && n < 50) begin @(negedge clk); n++; end
        bready = 1'b0; awaddr = 16'h0008; wdata = 32'h1357_9BDF; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        m_scratch = 32'h1357_9BDF;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({bvalid, awready, wready} !== 3'b100) begin failures++; $display("FAIL bready_hold_%0d got=%b exp=100", i, {bvalid, awready, wready}); end
            @(negedge clk);
        end
        bready = 1'b1;
        @(negedge clk);
        checks++;
        if ({bvalid, awready, wready} !== 3'b000) begin failures++; $display("FAIL bready_release got=%b exp=000", {bvalid, awready, wready}); end
        @(negedge clk);
        checks++;
        if ({awready, wready} !== 2'b11) begin failures++; $display("FAIL ready_reassert got=%b exp=11", {awready, wready}); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d, up, wd; logic [1:0] r; int lat, n;
        n = 0;
        while (!(awready && wready) && n < 50) begin @(negedge clk); n++; end
        bready = 1'b0; awaddr = 16'h0008; wdata = 32'hFFFF_0000; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        checks++;
        if (bvalid !== 1'b1) begin failures++; $display("FAIL mid_bvalid_pending got=%b exp=1", bvalid); end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({bvalid, awready, wready, arready} !== 4'b0000) begin failures++; $display("FAIL mid_reset_async got=%b exp=0000", {bvalid, awready, wready, arready}); end
        m_scratch = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0; bready = 1'b1;
        wd = $urandom;
        do_write(16'h0008, wd, 4'b0011, 0, r, lat);
        m_scratch = merge(m_scratch, wd, 4'b0011);
        checks++;
        if (r !== 2'b00 || lat != 1) begin failures++; $display("FAIL post_reset_wr got=%b/%0d exp=00/1", r, lat); end
        do_read(16'h0008, d, r, up, lat);
        checks++;
        if ({r, d} !== {2'b00, m_scratch}) begin failures++; $display("FAIL post_reset_rd got=%h exp=%h", {r, d}, {2'b00, m_scratch}); end
    endtask

    initial begin
        test_reset();
        test_golden();
        test_scratch();
        test_id_errors();
        test_uptime();
        test_concurrent();
        test_back_to_back();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
